// File: rtl/lz77_stream_dec_if.sv
// ============================================================================
//  Module      : lz77_stream_dec_if
//  Description : Tuple-in / byte-out bundle for the streaming LZ77 decoder.
//                The master side presents (offset, length, literal) tuples
//                and observes the decoded byte stream; the slave side is the
//                decoder itself.
//  Signals     : code_valid  tuple present on code_pos/code_len/chardata
//                code_pos    [3:0] match offset, 0 = newest history byte
//                code_len    [3:0] match length 0..15
//                chardata    [7:0] literal following the match
//                busy        tuple being expanded; accepted only when low
//                valid       char_nxt carries a decoded byte
//                char_nxt    [7:0] decoded byte
//                done        pulse with the end-marker byte
//                err         offset-error pulse (optional feature)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface lz77_stream_dec_if;
    logic       code_valid;
    logic [3:0] code_pos;
    logic [3:0] code_len;
    logic [7:0] chardata;
    logic       busy;
    logic       valid;
    logic [7:0] char_nxt;
    logic       done;
    logic       err;

    modport master (
        output code_valid, code_pos, code_len, chardata,
        input  busy, valid, char_nxt, done, err
    );

    modport slave (
        input  code_valid, code_pos, code_len, chardata,
        output busy, valid, char_nxt, done, err
    );
endinterface

`default_nettype wire

// File: rtl/lz77_stream_dec.sv
// ============================================================================
//  Module      : lz77_stream_dec
//  Description : Streaming LZ77 decoder. Expands one (offset, length,
//                literal) tuple at a time into a byte stream, one byte per
//                cycle, using a SEARCH_LEN-deep sliding history window.
//                Emitting END_CHAR as a literal pulses done and wipes the
//                history so the next string starts from a clean window.
//  Ports       : clk    rising-edge clock
//                reset  asynchronous, active-high reset
//                bus    lz77_stream_dec_if.slave (tuple in, byte out)
//  Options     : LZ77_DEC_OFFSET_CHK_EN - when defined, err pulses one cycle
//                after accepting a tuple whose match offset points past the
//                bytes written so far. When undefined err is tied low and no
//                fill tracking exists.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lz77_stream_dec #(
    parameter int         SEARCH_LEN = 9,
    parameter logic [7:0] END_CHAR   = 8'h45
) (
    input  logic               clk,
    input  logic               reset,
    lz77_stream_dec_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_COPY = 2'd1,
        S_LIT  = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_off;
    logic [3:0] r_cnt;
    logic [7:0] r_lit;
    logic [7:0] r_hist [SEARCH_LEN];
    logic       r_busy;
    logic       r_valid;
    logic [7:0] r_char;
    logic       r_done;
    logic [7:0] w_rd;

`ifdef LZ77_DEC_OFFSET_CHK_EN
    logic [3:0] r_fill;
    logic       r_err;
`endif

    // History read port. Offsets beyond the window fall through to 8'h00,
    // matching the cleared state of never-written entries.
    always_comb begin
        w_rd = 8'h00;
        for (int i = 0; i < SEARCH_LEN; i++) begin
            if (r_off == 4'(i)) begin
                w_rd = r_hist[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_off   <= 4'd0;
            r_cnt   <= 4'd0;
            r_lit   <= 8'h00;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_char  <= 8'h00;
            r_done  <= 1'b0;
            for (int i = 0; i < SEARCH_LEN; i++) begin
                r_hist[i] <= 8'h00;
            end
`ifdef LZ77_DEC_OFFSET_CHK_EN
            r_fill  <= 4'd0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef LZ77_DEC_OFFSET_CHK_EN
            r_err  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    if (bus.code_valid) begin
                        r_off   <= bus.code_pos;
                        r_cnt   <= bus.code_len;
                        r_lit   <= bus.chardata;
                        r_busy  <= 1'b1;
                        r_state <= (bus.code_len != 4'd0) ? S_COPY : S_LIT;
`ifdef LZ77_DEC_OFFSET_CHK_EN
                        r_err   <= (bus.code_len != 4'd0) && (bus.code_pos >= r_fill);
`endif
                    end
                end

                S_COPY: begin
                    // Offset is held for the whole copy, so a match longer
                    // than its offset re-reads bytes it just produced.
                    r_valid <= 1'b1;
                    r_char  <= w_rd;
                    for (int i = SEARCH_LEN - 1; i > 0; i--) begin
                        r_hist[i] <= r_hist[i-1];
                    end
                    r_hist[0] <= w_rd;
`ifdef LZ77_DEC_OFFSET_CHK_EN
                    if (r_fill != 4'(SEARCH_LEN)) begin
                        r_fill <= r_fill + 4'd1;
                    end
`endif
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_LIT;
                    end
                end

                S_LIT: begin
                    r_valid <= 1'b1;
                    r_char  <= r_lit;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (r_lit == END_CHAR) begin
                        // End of string: the marker itself is not kept and
                        // the next string decodes against an empty window.
                        r_done <= 1'b1;
                        for (int i = 0; i < SEARCH_LEN; i++) begin
                            r_hist[i] <= 8'h00;
                        end
`ifdef LZ77_DEC_OFFSET_CHK_EN
                        r_fill <= 4'd0;
`endif
                    end else begin
                        for (int i = SEARCH_LEN - 1; i > 0; i--) begin
                            r_hist[i] <= r_hist[i-1];
                        end
                        r_hist[0] <= r_lit;
`ifdef LZ77_DEC_OFFSET_CHK_EN
                        if (r_fill != 4'(SEARCH_LEN)) begin
                            r_fill <= r_fill + 4'd1;
                        end
`endif
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.valid    = r_valid;
    assign bus.char_nxt = r_char;
    assign bus.done     = r_done;
`ifdef LZ77_DEC_OFFSET_CHK_EN
    assign bus.err      = r_err;
`else
    assign bus.err      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lz77_stream_dec.sv
// ============================================================================
//  Module      : tb_lz77_stream_dec
//  Description : Self-checking bench for lz77_stream_dec. A reference LZ77
//                decoder model queues expected bytes as tuples are driven;
//                a negedge monitor pops and compares them as the DUT emits.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lz77_stream_dec;

    localparam int         SL = 9;
    localparam logic [7:0] EC = 8'h45;

    typedef struct {
        logic [7:0] ch;
        logic       done;
        logic       last;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lz77_stream_dec_if bus();

    lz77_stream_dec #(
        .SEARCH_LEN (SL),
        .END_CHAR   (EC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         checks   = 0;
    int         errors   = 0;
    int         cyc      = 0;
    int         n_out    = 0;
    int         last_acc = 0;
    int         last_len = 0;
    exp_t       q[$];
    exp_t       m_e;
    logic [7:0] mh [SL];
    int         mfill;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h required %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_clear();
        for (int i = 0; i < SL; i++) mh[i] = 8'h00;
        mfill = 0;
    endfunction

    function automatic void model_emit(input logic [7:0] b, input logic last);
        if (last && b == EC) begin
            q.push_back('{b, 1'b1, 1'b1});
            model_clear();
        end else begin
            q.push_back('{b, 1'b0, last});
            for (int i = SL - 1; i > 0; i--) mh[i] = mh[i-1];
            mh[0] = b;
            if (mfill < SL) mfill++;
        end
    endfunction

    function automatic void model_tuple(input logic [3:0] pos, input logic [3:0] len,
                                        input logic [7:0] ch);
        logic [7:0] b;
        for (int i = 0; i < int'(len); i++) begin
            b = (int'(pos) < SL) ? mh[pos] : 8'h00;
            model_emit(b, 1'b0);
        end
        model_emit(ch, 1'b1);
    endfunction

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", {31'd0, bus.valid}, 32'd0);
                end else begin
                    m_e = q.pop_front();
                    chk("char_nxt", {24'd0, bus.char_nxt}, {24'd0, m_e.ch});
                    chk("done", {31'd0, bus.done}, {31'd0, m_e.done});
                    chk("busy_in_output", {31'd0, bus.busy}, {31'd0, ~m_e.last});
                    n_out++;
                end
            end else if (bus.done) begin
                chk("done_without_valid", {31'd0, bus.done}, 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Call at negedge + 1.
    task automatic do_reset();
        reset = 1'b1;
        q.delete();
        model_clear();
        #1;
        chk("rst_busy",  {31'd0, bus.busy},  32'd0);
        chk("rst_valid", {31'd0, bus.valid}, 32'd0);
        chk("rst_char",  {24'd0, bus.char_nxt}, 32'd0);
        chk("rst_done",  {31'd0, bus.done},  32'd0);
        chk("rst_err",   {31'd0, bus.err},   32'd0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic send(input logic [3:0] pos, input logic [3:0] len, input logic [7:0] ch,
                        input bit junk, input bit b2b);
        int   i;
        logic exp_err;
        @(negedge clk);
        for (i = 0; i < 200 && bus.busy; i++) begin
            if (junk) begin
                bus.code_valid = 1'b1;
                bus.code_pos   = 4'($urandom);
                bus.code_len   = 4'($urandom);
                bus.chardata   = 8'($urandom);
            end
            @(negedge clk);
        end
        if (bus.busy) chk("accept_timeout", {31'd0, bus.busy}, 32'd0);
        bus.code_valid = 1'b1;
        bus.code_pos   = pos;
        bus.code_len   = len;
        bus.chardata   = ch;
`ifdef LZ77_DEC_OFFSET_CHK_EN
        exp_err = (len != 4'd0) && (int'(pos) >= mfill);
`else
        exp_err = 1'b0;
`endif
        model_tuple(pos, len, ch);
        @(posedge clk);
        @(negedge clk);
        chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        chk("err", {31'd0, bus.err}, {31'd0, exp_err});
        if (b2b) chk("accept_spacing", 32'(cyc - last_acc), 32'(last_len + 2));
        last_acc = cyc;
        last_len = int'(len);
    endtask

    task automatic drain();
        bus.code_valid = 1'b0;
        for (int i = 0; i < 400 && (q.size() != 0 || bus.busy); i++) @(negedge clk);
        chk("drain_queue", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
        chk("valid_idle", {31'd0, bus.valid}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.code_valid = 1'b0;
        bus.code_pos   = 4'd0;
        bus.code_len   = 4'd0;
        bus.chardata   = 8'h00;
        model_clear();
        @(negedge clk); #1;
        do_reset();

        // single literal
        send(4'd0, 4'd0, "a", 0, 0);
        drain();

        // literals then a copy
        @(negedge clk); #1; do_reset();
        send(4'd0, 4'd0, "a", 0, 0);
        send(4'd0, 4'd0, "b", 0, 1);
        send(4'd1, 4'd2, "c", 0, 1);
        drain();

        // overlapping match
        @(negedge clk); #1; do_reset();
        send(4'd0, 4'd0, "x", 0, 0);
        send(4'd0, 4'd6, "y", 0, 1);
        drain();

        // end marker clears the window
        @(negedge clk); #1; do_reset();
        send(4'd0, 4'd0, "q", 0, 0);
        send(4'd0, 4'd0, EC,  0, 1);
        send(4'd0, 4'd1, "z", 0, 1);
        drain();

        // junk held on the bus while busy; back-to-back acceptance
        @(negedge clk); #1; do_reset();
        send(4'd0, 4'd0, "h", 0, 0);
        send(4'd0, 4'd4, "d", 1, 1);
        send(4'd1, 4'd3, "e", 1, 1);
        send(4'd2, 4'd0, "f", 1, 1);
        send(4'd12, 4'd2, "g", 1, 1);
        drain();

        // reset mid-copy
        @(negedge clk); #1; do_reset();
        base = n_out;
        send(4'd0, 4'd7, "k", 0, 0);
        bus.code_valid = 1'b0;
        for (int i = 0; i < 100 && n_out < base + 3; i++) begin
            @(negedge clk); #1;
        end
        chk("abort_byte_count", 32'(n_out - base), 32'd3);
        do_reset();
        send(4'd2, 4'd1, "m", 0, 0);
        drain();

        // random tuples, chained back to back
        @(negedge clk); #1; do_reset();
        for (int t = 0; t < 30; t++) begin
            logic [7:0] c;
            c = ($urandom_range(0, 5) == 0) ? EC : 8'($urandom_range(8'h61, 8'h7a));
            send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 6)), c, t[0], t != 0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
